// File: rtl/posit_pkg.sv
// Shared posit helpers: width math, extractor FSM states and special-word patterns.
package posit_pkg;

  localparam int POSIT_N_DEFAULT  = 8;
  localparam int POSIT_ES_DEFAULT = 3;

  function automatic int posit_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  // NaR is the sign bit alone; zero is the all-clear word.
  function automatic logic [63:0] posit_nar_word(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] posit_zero_word(input int n);
    return 64'd0 & (64'd1 << (n - 1));
  endfunction

  typedef enum logic [1:0] {IDLE, SCAN, EXTRACT, DONE} extract_state_t;

endpackage

// File: rtl/posit_field_align.sv
// Left-aligns the bits below the regime terminator and splits them into exponent and fraction.
module posit_field_align import posit_pkg::*; #(
  parameter int N  = POSIT_N_DEFAULT,
  parameter int ES = POSIT_ES_DEFAULT,
  parameter int RS = posit_log2(N)
) (
  input  logic [N-1:0]  abs_word,
  input  logic [RS:0]   nbits,
  output logic [ES-1:0] exp_bits,
  output logic [N-1:0]  frac
);

  localparam int SW = RS + 1;

  logic [SW-1:0] sh;
  logic [N-1:0]  aligned;

  // Shifting by N - nbits drops the sign/regime/terminator and leaves zero fill below.
  always_comb begin
    sh       = SW'(N) - nbits;
    aligned  = abs_word << sh;
    exp_bits = aligned[N-1 -: ES];
    frac     = N'({1'b1, aligned[N-ES-1:0]}) << (ES - 1);
  end

endmodule

// File: rtl/posit_field_extract.sv
// Posit decoder front end: serial regime scan, then one-cycle exponent/fraction extraction.
module posit_field_extract import posit_pkg::*; #(
  parameter int N  = POSIT_N_DEFAULT,
  parameter int ES = POSIT_ES_DEFAULT,
  parameter int RS = posit_log2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_posit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               Sign,
  output logic signed [RS:0] R_O,
  output logic [ES-1:0]      E_O,
  output logic [N-1:0]       Frac,
  output logic               Zero,
  output logic               NaR
);

  // Handshake: a word moves when valid and ready are both high on a rising edge;
  // in_ready is high only in IDLE, out_valid only in DONE, and outputs hold while waiting.
  localparam logic [N-1:0] NAR_WORD  = N'(posit_nar_word(N));
  localparam logic [N-1:0] ZERO_WORD = N'(posit_zero_word(N));

  extract_state_t state, state_d;

  logic [N-1:0]  abs_q;
  logic [RS:0]   run_q;
  logic [RS-1:0] idx_q;
  logic          ref_q;
  logic [RS:0]   nbits_q;
  logic [N-1:0]  abs_in;
  logic          is_zero, is_nar, scan_bit;
  logic [ES-1:0] align_e;
  logic [N-1:0]  align_frac;

  assign abs_in   = in_posit[N-1] ? (~in_posit + 1'b1) : in_posit;
  assign is_zero  = (in_posit == ZERO_WORD);
  assign is_nar   = (in_posit == NAR_WORD);
  assign scan_bit = abs_q[idx_q];

  posit_field_align #(.N(N), .ES(ES), .RS(RS)) u_align (
    .abs_word (abs_q),
    .nbits    (nbits_q),
    .exp_bits (align_e),
    .frac     (align_frac)
  );

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (is_zero || is_nar) ? DONE : SCAN;
      end
      SCAN: begin
        if ((scan_bit != ref_q) || (idx_q == '0)) state_d = EXTRACT;
      end
      EXTRACT: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_q   <= '0;
      run_q   <= '0;
      idx_q   <= '0;
      ref_q   <= 1'b0;
      nbits_q <= '0;
      Sign    <= 1'b0;
      R_O     <= '0;
      E_O     <= '0;
      Frac    <= '0;
      Zero    <= 1'b0;
      NaR     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            Sign <= in_posit[N-1];
            if (is_zero || is_nar) begin
              Zero <= is_zero;
              NaR  <= is_nar;
              R_O  <= '0;
              E_O  <= '0;
              Frac <= '0;
            end else begin
              abs_q <= abs_in;
              run_q <= (RS+1)'(1);
              idx_q <= RS'(N - 3);
              ref_q <= abs_in[N-2];
            end
          end
        end
        SCAN: begin
          if (scan_bit == ref_q) begin
            run_q <= run_q + 1'b1;
            if (idx_q == '0) nbits_q <= '0;
            else             idx_q   <= idx_q - 1'b1;
          end else begin
            // Everything strictly below the terminator is exponent/fraction payload.
            nbits_q <= {1'b0, idx_q};
          end
        end
        EXTRACT: begin
          R_O  <= ref_q ? $signed(run_q - 1'b1) : -$signed(run_q);
          E_O  <= align_e;
          Frac <= align_frac;
          Zero <= 1'b0;
          NaR  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_field_extract.sv
// Directed bench for posit_field_extract (N=8, ES=3) with hand-computed expected fields.
module tb_posit_field_extract;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_posit;
  logic              out_valid;
  logic              out_ready;
  logic              Sign;
  logic signed [3:0] R_O;
  logic [2:0]        E_O;
  logic [7:0]        Frac;
  logic              Zero;
  logic              NaR;

  int checks = 0;
  int errors = 0;

  posit_field_extract #(.N(8), .ES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sign      (Sign),
    .R_O       (R_O),
    .E_O       (E_O),
    .Frac      (Frac),
    .Zero      (Zero),
    .NaR       (NaR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_posit = 8'h00; out_ready = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, Sign, R_O, E_O, Frac, Zero, NaR} !== {1'b1, 1'b0, 1'b0, 4'h0, 3'h0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b val=%b S=%b R=%0d E=%0d F=%h Z=%b N=%b, required rdy=1 rest 0",
               in_ready, out_valid, Sign, R_O, E_O, Frac, Zero, NaR);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_decode(input logic [7:0] w, input logic s, input logic signed [3:0] r,
                             input logic [2:0] e, input logic [7:0] f, input logic z,
                             input logic n, input int lat);
    int  edges;
    bit  seen;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready_%h: in_ready=%b required 1", w, in_ready);
    end
    in_valid = 1'b1; in_posit = w; out_ready = 1'b0;
    edges = 0; seen = 0;
    while (!seen && edges < 20) begin
      @(posedge clk); edges++; #1;
      in_valid = 1'b0;
      if (out_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || edges != lat) begin
      errors++; $display("FAIL latency_%h: seen=%0d edges=%0d required %0d", w, seen, edges, lat);
    end
    checks++;
    if (Sign !== s) begin errors++; $display("FAIL sign_%h: got %b required %b", w, Sign, s); end
    checks++;
    if (R_O !== r) begin errors++; $display("FAIL regime_%h: got %0d required %0d", w, R_O, r); end
    checks++;
    if (E_O !== e) begin errors++; $display("FAIL exp_%h: got %0d required %0d", w, E_O, e); end
    checks++;
    if (Frac !== f) begin errors++; $display("FAIL frac_%h: got %h required %h", w, Frac, f); end
    checks++;
    if ({Zero, NaR} !== {z, n}) begin
      errors++; $display("FAIL flags_%h: got Z=%b N=%b required Z=%b N=%b", w, Zero, NaR, z, n);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL handshake_%h: val=%b rdy=%b required val=0 rdy=1", w, out_valid, in_ready);
    end
  endtask

  task automatic test_back_pressure();
    int  edges;
    @(negedge clk);
    in_valid = 1'b1; in_posit = 8'h59; out_ready = 1'b0;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 20) begin
      @(posedge clk); edges++; #1;
      in_valid = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: out_valid=%b required 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_posit = 8'h0C;
      checks++;
      if ({out_valid, in_ready, Sign, R_O, E_O, Frac, Zero, NaR} !== {1'b1, 1'b0, 1'b0, 4'h0, 3'd6, 8'hA0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold_%0d: val=%b rdy=%b S=%b R=%0d E=%0d F=%h, required val=1 rdy=0 S=0 R=0 E=6 F=a0",
                 i, out_valid, in_ready, Sign, R_O, E_O, Frac);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, E_O, Frac} !== {1'b0, 1'b1, 3'd6, 8'hA0}) begin
      errors++;
      $display("FAIL bp_release: val=%b rdy=%b E=%0d F=%h, required val=0 rdy=1 E=6 F=a0", out_valid, in_ready, E_O, Frac);
    end
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    in_valid = 1'b1; in_posit = 8'h7F; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, Sign, R_O, E_O, Frac, Zero, NaR} !== {1'b0, 1'b1, 1'b0, 4'h0, 3'h0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL scan_reset: val=%b rdy=%b S=%b R=%0d E=%0d F=%h, required val=0 rdy=1 all fields 0",
               out_valid, in_ready, Sign, R_O, E_O, Frac);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL scan_reset_idle: val=%b rdy=%b required val=0 rdy=1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_decode(8'h59, 1'b0,  4'sd0, 3'd6, 8'hA0, 1'b0, 1'b0, 3);
    test_decode(8'hA7, 1'b1,  4'sd0, 3'd6, 8'hA0, 1'b0, 1'b0, 3);
    test_decode(8'h0C, 1'b0, -4'sd3, 3'd4, 8'h80, 1'b0, 1'b0, 5);
    test_decode(8'h7F, 1'b0,  4'sd6, 3'd0, 8'h80, 1'b0, 1'b0, 8);
    test_decode(8'h7D, 1'b0,  4'sd4, 3'd4, 8'h80, 1'b0, 1'b0, 7);
    test_decode(8'h01, 1'b0, -4'sd6, 3'd0, 8'h80, 1'b0, 1'b0, 8);
    test_decode(8'hFF, 1'b1, -4'sd6, 3'd0, 8'h80, 1'b0, 1'b0, 8);
    test_decode(8'h40, 1'b0,  4'sd0, 3'd0, 8'h80, 1'b0, 1'b0, 3);
    test_decode(8'h00, 1'b0,  4'sd0, 3'd0, 8'h00, 1'b1, 1'b0, 1);
    test_decode(8'h80, 1'b1,  4'sd0, 3'd0, 8'h00, 1'b0, 1'b1, 1);
    test_back_pressure();
    test_reset_mid_scan();
    test_decode(8'h59, 1'b0,  4'sd0, 3'd6, 8'hA0, 1'b0, 1'b0, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
